// File: rtl/codeword_packer_if.sv
// Handshake bundle between the word-length generator, the packer and the
// compressed-data output buffer. The packer connects through the slave modport.
interface codeword_packer_if #(
  parameter int OUT_W   = 32,
  parameter int MAX_LEN = 34
);
  // Codeword side (upstream -> packer)
  logic               i_valid;
  logic [MAX_LEN-1:0] i_code;
  logic [5:0]         i_length;
  logic               o_ready;
  logic               i_flush;

  // Packed word side (packer -> downstream)
  logic [OUT_W-1:0]   o_word;
  logic               o_valid;
  logic               i_ready;
  logic               o_last;
  logic               o_flush_done;

  modport master (
    output i_valid, i_code, i_length, i_flush, i_ready,
    input  o_ready, o_word, o_valid, o_last, o_flush_done
  );

  modport slave (
    input  i_valid, i_code, i_length, i_flush, i_ready,
    output o_ready, o_word, o_valid, o_last, o_flush_done
  );
endinterface

// File: rtl/codeword_packer.sv
// Variable-length codeword packer: appends 0..MAX_LEN-bit codewords MSB-first
// into an ACC_W-bit accumulator and emits OUT_W-bit words from its top. A flush
// drains every held bit, padding the final partial word with zeros.
module codeword_packer #(
  parameter int OUT_W   = 32,
  parameter int MAX_LEN = 34,
  parameter int ACC_W   = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  codeword_packer_if.slave bus
);

  localparam int CNT_W = $clog2(ACC_W) + 1;
  localparam int LEN_W = 6;

  localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] ACC_CNT = CNT_W'(ACC_W);
  // Room needed for a longest codeword after this cycle's emit.
  localparam logic [CNT_W-1:0] ACC_LIM = CNT_W'(ACC_W - MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CNT_W-1:0]   cnt_e;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] code_m;
  logic [CNT_W-1:0]   shamt;
  logic [ACC_W-1:0]   acc_sh;
  logic               valid;
  logic               last;
  logic               ready;
  logic               emit;
  logic               accept;

  // Output word comes straight from the register; valid/last depend only on state.
  assign valid  = (cnt_q >= OUT_CNT) || ((state_q == ST_FLUSH) && (cnt_q != '0));
  assign last   = (state_q == ST_FLUSH) && (cnt_q != '0) && (cnt_q <= OUT_CNT);
  assign emit   = valid && bus.i_ready;
  assign ready  = (state_q == ST_RUN) && (cnt_e <= ACC_LIM);
  assign accept = bus.i_valid && ready;

  assign bus.o_word       = acc_q[ACC_W-1 -: OUT_W];
  assign bus.o_valid      = valid;
  assign bus.o_last       = last;
  assign bus.o_ready      = ready;
  assign bus.o_flush_done = (state_q == ST_DONE);

  // Post-emit fill level; a padded final word empties the accumulator entirely.
  always_comb begin
    cnt_e = cnt_q;
    if (emit) begin
      cnt_e = (cnt_q >= OUT_CNT) ? (cnt_q - OUT_CNT) : '0;
    end
  end

  // Accumulator datapath: drop the emitted word, then place the masked code just below held bits.
  always_comb begin
    len    = (bus.i_length > MAX_L) ? MAX_L : bus.i_length;
    code_m = bus.i_code & ~({MAX_LEN{1'b1}} << len);
    shamt  = ACC_CNT - cnt_e - CNT_W'(len);
    acc_sh = emit ? (acc_q << OUT_W) : acc_q;
    acc_d  = acc_sh;
    cnt_d  = cnt_e;
    if (accept) begin
      acc_d = acc_sh | (ACC_W'(code_m) << shamt);
      cnt_d = cnt_e + CNT_W'(len);
    end
  end

  // Flush sequencing: RUN -> FLUSH on request, FLUSH -> DONE once the last word leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (bus.i_flush) state_d = ST_FLUSH;
      ST_FLUSH: if ((cnt_q == '0) || (emit && last)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // State, accumulator and bit count registers; reset discards all held bits.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_codeword_packer.sv
// Directed bench for codeword_packer: stimulus pushes hand-computed words into
// a scoreboard queue, a monitor pops and compares on every output handshake.
module tb_codeword_packer;

  logic clk;
  logic rst_n;

  codeword_packer_if #(.OUT_W(32), .MAX_LEN(34)) bus ();

  codeword_packer #(.OUT_W(32), .MAX_LEN(34), .ACC_W(64)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got=%0h expected=none", bus.o_word);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word", bus.o_word, e.w);
        chk("last", bus.o_last, e.l);
      end
    end
  end

  task automatic send(input logic [33:0] c, input logic [5:0] l);
    int n = 0;
    bus.i_valid  = 1'b1;
    bus.i_code   = c;
    bus.i_length = l;
    @(negedge clk);
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_n);
    int n = 0;
    while (!bus.o_flush_done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 64'(n), 64'(exp_n));
  endtask

  task automatic push(input logic [31:0] w, input logic l);
    exp_t e;
    e.w = w;
    e.l = l;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_code   = '0;
    bus.i_length = '0;
    bus.i_flush  = 1'b0;
    bus.i_ready  = 1'b1;
    #2;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_last", bus.o_last, 0);
    chk("rst_done", bus.o_flush_done, 0);
    chk("rst_word", bus.o_word, 0);
    chk("rst_ready", bus.o_ready, 1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill one word with 16 x "01"
    push(32'h5555_5555, 1'b0);
    for (int i = 0; i < 16; i++) send(34'h1, 6'd2);
    chk("fill_valid", bus.o_valid, 1);
    chk("fill_word", bus.o_word, 32'h5555_5555);
    @(posedge clk);
    #1;
    chk("fill_empty_valid", bus.o_valid, 0);

    // Bits above the length are ignored; zero length is a no-op; length is clipped to 34
    push(32'hF000_0000, 1'b0);
    send(34'h3_FFFF_FFFF, 6'd4);
    send(34'h3FF, 6'd0);
    send(34'h0, 6'd28);
    push(32'hFFFF_FFFF, 1'b0);
    push(32'hFFFF_FFFF, 1'b0);
    send(34'h3_FFFF_FFFF, 6'd63);
    send(34'h3_FFFF_FFFF, 6'd30);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("clip_empty_valid", bus.o_valid, 0);

    // Two 34-bit codes, second accepted alongside the first emit, then flush
    push(32'hFFFF_FFFF, 1'b0);
    push(32'hFFFF_FFFF, 1'b0);
    push(32'hF000_0000, 1'b1);
    send(34'h3_FFFF_FFFF, 6'd34);
    bus.i_valid  = 1'b1;
    bus.i_code   = 34'h3_FFFF_FFFF;
    bus.i_length = 6'd34;
    #1;
    chk("long_emit_and_accept", {bus.o_valid, bus.o_ready}, 2'b11);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    pulse_flush();
    chk("long_final_word", bus.o_word, 32'hF000_0000);
    chk("long_final_last", bus.o_last, 1);
    chk("long_flush_ready", bus.o_ready, 0);
    wait_done("long_done_delay", 1);
    @(posedge clk);
    #1;
    chk("long_done_pulse_width", bus.o_flush_done, 0);

    // Partial flush: 101101 110011 -> B73 padded
    push(32'hB730_0000, 1'b1);
    send(34'h2D, 6'd6);
    send(34'h33, 6'd6);
    pulse_flush();
    chk("partial_word", bus.o_word, 32'hB730_0000);
    chk("partial_last", bus.o_last, 1);
    wait_done("partial_done_delay", 1);

    // Empty flush: nothing emitted, done two cycles after the request
    @(posedge clk);
    #1;
    pulse_flush();
    chk("empty_valid", bus.o_valid, 0);
    wait_done("empty_done_delay", 1);

    // Backpressure with 40 bits held
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    push(32'hABCD_E123, 1'b0);
    push(32'h450F_0000, 1'b1);
    send(34'hABCDE, 6'd20);
    send(34'h12345, 6'd20);
    bus.i_valid  = 1'b1;
    bus.i_code   = 34'h0F;
    bus.i_length = 6'd8;
    for (int i = 0; i < 10; i++) begin
      chk("bp_word_stable", bus.o_word, 32'hABCD_E123);
      chk("bp_ready_low", {bus.o_valid, bus.o_ready}, 2'b10);
      @(posedge clk);
      #1;
    end
    bus.i_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.o_ready, 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    pulse_flush();
    wait_done("bp_done_delay", 1);

    // Reset with 20 bits held discards them
    @(posedge clk);
    #1;
    send(34'hABCDE, 6'd20);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.o_valid, 0);
    chk("midrst_word", bus.o_word, 0);
    chk("midrst_ready", bus.o_ready, 1);
    chk("midrst_last", bus.o_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_after_valid", bus.o_valid, 0);
    push(32'h1234_5678, 1'b0);
    send(34'h1234_5678, 6'd32);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
